fetch_decode_32: RTL
====================

// Module: fetch_decode_32
// PURPOSE
//  Upstream stage of regalumem. Holds the PC and fetches 32-bit MIPS words over a req/valid
//  instruction-memory handshake. Decodes each word into rd/rs/rt/immediate/alu_control plus
//  control strobes, and presents one decoded instruction at a time under a valid/ready handshake.
//  Handles branch redirect and squashes in-flight fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
// PORTS
//  clock                  in   1   single system clock, rising edge
//  reset_n                in   1   asynchronous, active-low reset
//  imem_req               out  1   fetch request, held high until imem_valid
//  imem_addr              out  32  byte address of fetch (= pc), stable while imem_req=1
//  imem_data              in   32  instruction word, sampled when imem_valid=1
//  imem_valid             in   1   one-cycle strobe: imem_data holds the requested word
//  branch_taken           in   1   redirect strobe from the execute stage
//  branch_target          in   32  redirect address; bits [1:0] forced to 0
//  issue_ready            in   1   downstream accepts the decoded instruction this cycle
//  out_valid              out  1   decoded outputs below are valid
//  pc_out                 out  32  address of the presented instruction
//  rd                     out  5   destination register: instr[15:11] for R-type, instr[20:16] for I-type
//  rs                     out  5   instr[25:21]
//  rt                     out  5   instr[20:16]
//  immediate              out  16  instr[15:0]
//  alu_control            out  2   00 add, 01 sub, 10 and, 11 or
//  use_immediate          out  1   ALU B operand = sign-extended immediate
//  reg_write              out  1   write rd in the register file
//  mem_read               out  1   load
//  mem_write              out  1   store
//  err_invalid_instruction out 1   high with out_valid when the word is unsupported
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - pc=RESET_PC; state=IDLE; squash=0.
//   - All outputs 0; imem_req deasserts immediately, without waiting for a clock edge.
//   - Any fetch outstanding at reset is abandoned.
//  State machine (registered, one transition per clock):
//   - IDLE:  always -> FETCH on the next edge (one dead cycle after reset release).
//   - FETCH: imem_req=1, imem_addr=pc -> WAIT.
//   - WAIT:  imem_req=1 held until imem_valid.
//       On imem_valid with squash=0: register the decode, out_valid=1, pc<=pc+4 -> ISSUE.
//       On imem_valid with squash=1: discard the word, squash<=0 -> FETCH.
//   - ISSUE: outputs held stable while issue_ready=0. On issue_ready=1: out_valid<=0 -> FETCH.
//  Throughput: one instruction per (3 + memory wait) cycles; no prefetch.
//  Decode table (anything else: err_invalid_instruction=1, reg_write=mem_read=mem_write=0):
//   - op 000000, funct 100000 add / 100010 sub / 100100 and / 100101 or:
//       alu_control 00/01/10/11, reg_write=1, use_immediate=0.
//   - op 001000 addi: alu 00, use_immediate=1, reg_write=1.
//   - op 100011 lw:   alu 00, use_immediate=1, reg_write=1, mem_read=1.
//   - op 101011 sw:   alu 00, use_immediate=1, mem_write=1, reg_write=0.
//   - Word 32'h0 (sll $0 nop): valid; all strobes 0; err_invalid_instruction=0.
//  Branch redirect (branch_taken=1, any state except IDLE):
//   - pc<={branch_target[31:2],2'b00} on that edge; out_valid<=0.
//   - In ISSUE: the current instruction is dropped unless issue_ready=1 in the same cycle
//     (then it counts as accepted). Next state FETCH.
//   - In WAIT: squash<=1; the pending response is discarded when it arrives. imem_req stays
//     high until then, and imem_addr holds the old pc until that response.
//   - In WAIT coincident with imem_valid: the word is discarded -> FETCH.
//   - In FETCH: the edge moves to WAIT with squash<=1.
//   - In IDLE: branch_taken is ignored.
//  Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). pc_out = fetch address of the
//   presented word.
// TESTING
//  1. Release reset with imem_valid returned 1 cycle after req:
//     -> first imem_addr=RESET_PC; then 0x4, 0x8 in order.
//  2. imem_data=32'h012A4020 (add $8,$9,$10):
//     -> rs=9, rt=10, rd=8, alu_control=00, reg_write=1, out_valid=1.
//  3. imem_data=32'h8D280010 (lw $8,16($9)):
//     -> rd=8, immediate=16'h0010, use_immediate=1, mem_read=1.
//     With issue_ready=0 for 5 cycles, all outputs hold; the next fetch starts only after ready.
//  4. branch_taken=1, target=32'h0000_0103, asserted in WAIT:
//     -> the late response is discarded (out_valid stays 0); next imem_addr=32'h0000_0100.
//  5. RESET_PC=32'hFFFF_FFFC, one issue -> next imem_addr=0.
//     Unsupported op 6'b111111 -> err_invalid_instruction=1, all strobes 0.
//  6. Drop reset_n mid-WAIT -> imem_req=0 and out_valid=0 asynchronously.
//     After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_decode_32_if.sv
// Bus bundle for fetch_decode_32: the instruction-memory handshake, the branch redirect,
// and the decoded-issue handshake.
interface fetch_decode_32_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        issue_ready;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] immediate;
  logic [1:0]  alu_control;
  logic        use_immediate;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        err_invalid_instruction;

  modport master (
    output imem_req, imem_addr,
    input  imem_data, imem_valid,
    input  branch_taken, branch_target, issue_ready,
    output out_valid, pc_out, rd, rs, rt, immediate, alu_control,
    output use_immediate, reg_write, mem_read, mem_write, err_invalid_instruction
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_data, imem_valid,
    output branch_taken, branch_target, issue_ready,
    input  out_valid, pc_out, rd, rs, rt, immediate, alu_control,
    input  use_immediate, reg_write, mem_read, mem_write, err_invalid_instruction
  );
endinterface

// File: rtl/fetch_decode_32.sv
// PC holder, single-outstanding instruction fetch and MIPS-subset decoder. Presents one
// decoded instruction at a time and squashes fetches made stale by a branch redirect.
module fetch_decode_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clock,
  input logic               reset_n,
  fetch_decode_32_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StIssue} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        squash_q, squash_d;
  logic        out_valid_q, out_valid_d;
  logic        capture;
  logic [31:0] redirect_pc;

  logic [31:0] pc_out_q;
  logic [4:0]  rd_q, rs_q, rt_q;
  logic [15:0] imm_q;
  logic [1:0]  alu_q;
  logic        use_imm_q, reg_write_q, mem_read_q, mem_write_q, err_q;

  logic [5:0]  op, funct;
  logic [4:0]  dec_rd;
  logic [1:0]  dec_alu;
  logic        dec_use_imm, dec_reg_write, dec_mem_read, dec_mem_write, dec_err;

  assign op          = bus.imem_data[31:26];
  assign funct       = bus.imem_data[5:0];
  assign redirect_pc = bus.branch_target & ~32'h3;

  // Decode
  always_comb begin
    dec_alu       = 2'b00;
    dec_use_imm   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_err       = 1'b0;
    dec_rd        = (op == 6'b000000) ? bus.imem_data[15:11] : bus.imem_data[20:16];
    if (bus.imem_data != 32'h0) begin
      unique case (op)
        6'b000000: begin
          unique case (funct)
            6'b100000: begin dec_alu = 2'b00; dec_reg_write = 1'b1; end
            6'b100010: begin dec_alu = 2'b01; dec_reg_write = 1'b1; end
            6'b100100: begin dec_alu = 2'b10; dec_reg_write = 1'b1; end
            6'b100101: begin dec_alu = 2'b11; dec_reg_write = 1'b1; end
            default:   dec_err = 1'b1;
          endcase
        end
        6'b001000: begin dec_use_imm = 1'b1; dec_reg_write = 1'b1; end
        6'b100011: begin dec_use_imm = 1'b1; dec_reg_write = 1'b1; dec_mem_read = 1'b1; end
        6'b101011: begin dec_use_imm = 1'b1; dec_mem_write = 1'b1; end
        default:   dec_err = 1'b1;
      endcase
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    out_valid_d = out_valid_q;
    capture     = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        state_d = StWait;
        if (bus.branch_taken) begin
          pc_d     = redirect_pc;
          squash_d = 1'b1;
        end
      end
      StWait: begin
        if (bus.imem_valid) begin
          if (squash_q || bus.branch_taken) begin
            state_d  = StFetch;
            squash_d = 1'b0;
          end else begin
            capture     = 1'b1;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = StIssue;
          end
          if (bus.branch_taken) pc_d = redirect_pc;
        end else if (bus.branch_taken) begin
          // Response for the old address is still due; keep the request up and drop it later
          pc_d     = redirect_pc;
          squash_d = 1'b1;
        end
      end
      StIssue: begin
        if (bus.branch_taken || bus.issue_ready) begin
          out_valid_d = 1'b0;
          state_d     = StFetch;
        end
        if (bus.branch_taken) pc_d = redirect_pc;
      end
      default: state_d = StIdle;
    endcase
    // Fetch address is frozen from FETCH until the response returns
    addr_d = (state_d == StFetch) ? pc_d : addr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      squash_q    <= 1'b0;
      out_valid_q <= 1'b0;
      pc_out_q    <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      squash_q    <= squash_d;
      out_valid_q <= out_valid_d;
      if (capture) begin
        pc_out_q    <= addr_q;
        rd_q        <= dec_rd;
        rs_q        <= bus.imem_data[25:21];
        rt_q        <= bus.imem_data[20:16];
        imm_q       <= bus.imem_data[15:0];
        alu_q       <= dec_alu;
        use_imm_q   <= dec_use_imm;
        reg_write_q <= dec_reg_write;
        mem_read_q  <= dec_mem_read;
        mem_write_q <= dec_mem_write;
        err_q       <= dec_err;
      end
    end
  end

  assign bus.imem_req                = (state_q == StFetch) || (state_q == StWait);
  assign bus.imem_addr               = addr_q;
  assign bus.out_valid               = out_valid_q;
  assign bus.pc_out                  = pc_out_q;
  assign bus.rd                      = rd_q;
  assign bus.rs                      = rs_q;
  assign bus.rt                      = rt_q;
  assign bus.immediate               = imm_q;
  assign bus.alu_control             = alu_q;
  assign bus.use_immediate           = use_imm_q;
  assign bus.reg_write               = reg_write_q;
  assign bus.mem_read                = mem_read_q;
  assign bus.mem_write               = mem_write_q;
  assign bus.err_invalid_instruction = err_q;

endmodule
